// File: rtl/axi4_burst_to_axi4_stream.sv
// -----------------------------------------------------------------------------
// axi4_burst_to_axi4_stream
//
// Reads a packet of pkt_size_i bytes from AXI4 memory at addr_i. The start
// address is rounded down to the bus width. The data is issued as INCR read
// bursts of up to 256 beats, with only one burst outstanding at a time. Each
// R beat goes straight onto an AXI4-Stream master with zero latency:
// tvalid follows rvalid and rready follows tready, with no buffering.
//
// Optional feature (compile-time macro): AXI4_BURST_TO_STREAM_4K_SPLIT_EN
//   When defined, bursts are also cut at 4 KB address boundaries.
//
// The AXI4 master (burst_*) and the AXI4-Stream master (pkt_*) are flattened
// into individual ports. The write channel is tied off.
// DATA_WIDTH must be at least 16 bits and ADDR_WIDTH at least 12 bits.
//
// Ports
//   clk_i, rst_i          clock; asynchronous active-high reset
//   start_i               read request, sampled only while idle
//   pkt_size_i, addr_i    packet size (bytes) and start byte address
//   busy_o                high whenever a packet is in progress
//   rd_err_o              sticky: some RRESP != OKAY in the current packet
//   burst_aw*/w*/b*       AXI4 write channels (constant)
//   burst_ar*/r*          AXI4 read channels
//   pkt_t*                AXI4-Stream output
// -----------------------------------------------------------------------------
module axi4_burst_to_axi4_stream #(
  parameter int unsigned DATA_WIDTH         = 64,
  parameter int unsigned ADDR_WIDTH         = 32,
  parameter int unsigned ID_WIDTH           = 1,
  parameter int unsigned AWUSER_WIDTH       = 1,
  parameter int unsigned WUSER_WIDTH        = 1,
  parameter int unsigned ARUSER_WIDTH       = 1,
  parameter int unsigned MAX_PKT_SIZE_B     = 2048,
  parameter int unsigned MAX_PKT_SIZE_WIDTH = $clog2(MAX_PKT_SIZE_B)
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          start_i,
  input  logic [MAX_PKT_SIZE_WIDTH-1:0] pkt_size_i,
  input  logic [ADDR_WIDTH-1:0]         addr_i,
  output logic                          busy_o,
  output logic                          rd_err_o,
  // AXI4 write address channel (tied off)
  output logic [ID_WIDTH-1:0]           burst_awid_o,
  output logic [ADDR_WIDTH-1:0]         burst_awaddr_o,
  output logic [7:0]                    burst_awlen_o,
  output logic [2:0]                    burst_awsize_o,
  output logic [1:0]                    burst_awburst_o,
  output logic                          burst_awlock_o,
  output logic [3:0]                    burst_awcache_o,
  output logic [2:0]                    burst_awprot_o,
  output logic [3:0]                    burst_awqos_o,
  output logic [3:0]                    burst_awregion_o,
  output logic [AWUSER_WIDTH-1:0]       burst_awuser_o,
  output logic                          burst_awvalid_o,
  input  logic                          burst_awready_i,
  // AXI4 write data channel (tied off)
  output logic [DATA_WIDTH-1:0]         burst_wdata_o,
  output logic [DATA_WIDTH/8-1:0]       burst_wstrb_o,
  output logic                          burst_wlast_o,
  output logic [WUSER_WIDTH-1:0]        burst_wuser_o,
  output logic                          burst_wvalid_o,
  input  logic                          burst_wready_i,
  // AXI4 write response channel (always accepted)
  input  logic [ID_WIDTH-1:0]           burst_bid_i,
  input  logic [1:0]                    burst_bresp_i,
  input  logic                          burst_bvalid_i,
  output logic                          burst_bready_o,
  // AXI4 read address channel
  output logic [ID_WIDTH-1:0]           burst_arid_o,
  output logic [ADDR_WIDTH-1:0]         burst_araddr_o,
  output logic [7:0]                    burst_arlen_o,
  output logic [2:0]                    burst_arsize_o,
  output logic [1:0]                    burst_arburst_o,
  output logic                          burst_arlock_o,
  output logic [3:0]                    burst_arcache_o,
  output logic [2:0]                    burst_arprot_o,
  output logic [3:0]                    burst_arqos_o,
  output logic [3:0]                    burst_arregion_o,
  output logic [ARUSER_WIDTH-1:0]       burst_aruser_o,
  output logic                          burst_arvalid_o,
  input  logic                          burst_arready_i,
  // AXI4 read data channel
  input  logic [ID_WIDTH-1:0]           burst_rid_i,
  input  logic [DATA_WIDTH-1:0]         burst_rdata_i,
  input  logic [1:0]                    burst_rresp_i,
  input  logic                          burst_rlast_i,
  input  logic                          burst_rvalid_i,
  output logic                          burst_rready_o,
  // AXI4-Stream output
  output logic [DATA_WIDTH-1:0]         pkt_tdata_o,
  output logic [DATA_WIDTH/8-1:0]       pkt_tstrb_o,
  output logic [DATA_WIDTH/8-1:0]       pkt_tkeep_o,
  output logic                          pkt_tlast_o,
  output logic                          pkt_tvalid_o,
  input  logic                          pkt_tready_i
);

  localparam int unsigned DATA_WIDTH_B = DATA_WIDTH / 8;
  localparam int unsigned OFFS_W       = $clog2(DATA_WIDTH_B);
  // Word counter must hold both the packet word count and the value 256.
  localparam int unsigned WORDS_W = (MAX_PKT_SIZE_WIDTH + 1 > 10) ? MAX_PKT_SIZE_WIDTH + 1 : 10;

  typedef enum logic [1:0] {
    IDLE_S,
    CALC_BURST_S,
    ADDR_S,
    DATA_S
  } state_t;

  state_t                  state_q;
  logic                    arvalid_q;
  logic [ADDR_WIDTH-1:0]   araddr_q;
  logic [7:0]              arlen_q;
  logic [WORDS_W-1:0]      words_left_q;
  logic [ADDR_WIDTH-1:0]   cur_addr_q;
  logic [OFFS_W-1:0]       tail_q;
  logic                    rd_err_q;

  logic                    in_data;
  logic                    last_word;
  logic                    r_hs;
  logic [WORDS_W-1:0]      words_init;
  logic [WORDS_W-1:0]      burst_words;
  logic [DATA_WIDTH_B-1:0] strb_c;

  assign in_data   = (state_q == DATA_S);
  assign last_word = (words_left_q == WORDS_W'(1));
  assign r_hs      = in_data && burst_rvalid_i && pkt_tready_i;

  assign words_init = (WORDS_W'(pkt_size_i) + WORDS_W'(DATA_WIDTH_B - 1)) >> OFFS_W;

  // Length of the next burst: words remaining, capped at 256 beats
  // (and optionally cut at the next 4 KB boundary).
  always_comb begin
    burst_words = (words_left_q > WORDS_W'(256)) ? WORDS_W'(256) : words_left_q;
`ifdef AXI4_BURST_TO_STREAM_4K_SPLIT_EN
    begin
      logic [12:0] bytes_to_4k;
      logic [12:0] words_to_4k;
      bytes_to_4k = 13'h1000 - {1'b0, cur_addr_q[11:0]};
      words_to_4k = bytes_to_4k >> OFFS_W;
      // burst_words <= 256, so comparing in 13 bits is lossless.
      if (words_to_4k < 13'(burst_words)) begin
        burst_words = WORDS_W'(words_to_4k);
      end
    end
`endif
  end

  // On the final beat of a packet with a partial tail, only the low
  // tail_q bytes are valid.
  always_comb begin
    strb_c = '1;
    if (last_word && (tail_q != '0)) begin
      for (int unsigned i = 0; i < DATA_WIDTH_B; i++) begin
        if (i >= 32'(tail_q)) begin
          strb_c[i] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE_S;
      arvalid_q    <= 1'b0;
      araddr_q     <= '0;
      arlen_q      <= '0;
      words_left_q <= '0;
      cur_addr_q   <= '0;
      tail_q       <= '0;
      rd_err_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE_S: begin
          if (start_i && (pkt_size_i != '0)) begin
            words_left_q <= words_init;
            cur_addr_q   <= {addr_i[ADDR_WIDTH-1:OFFS_W], {OFFS_W{1'b0}}};
            tail_q       <= pkt_size_i[OFFS_W-1:0];
            rd_err_q     <= 1'b0;
            state_q      <= CALC_BURST_S;
          end
        end
        CALC_BURST_S: begin
          arlen_q   <= 8'(burst_words - WORDS_W'(1));
          araddr_q  <= cur_addr_q;
          arvalid_q <= 1'b1;
          state_q   <= ADDR_S;
        end
        ADDR_S: begin
          if (burst_arready_i) begin
            arvalid_q <= 1'b0;
            state_q   <= DATA_S;
          end
        end
        DATA_S: begin
          if (r_hs) begin
            words_left_q <= words_left_q - WORDS_W'(1);
            cur_addr_q   <= cur_addr_q + ADDR_WIDTH'(DATA_WIDTH_B);
            if (burst_rresp_i != 2'b00) begin
              rd_err_q <= 1'b1;
            end
            // The internal word count, not rlast, decides when the packet ends.
            if (last_word) begin
              state_q <= IDLE_S;
            end else if (burst_rlast_i) begin
              state_q <= CALC_BURST_S;
            end
          end
        end
        default: state_q <= IDLE_S;
      endcase
    end
  end

  assign busy_o   = (state_q != IDLE_S);
  assign rd_err_o = rd_err_q;

  assign burst_arid_o     = '0;
  assign burst_araddr_o   = araddr_q;
  assign burst_arlen_o    = arlen_q;
  assign burst_arsize_o   = 3'(OFFS_W);
  assign burst_arburst_o  = 2'b01;
  assign burst_arlock_o   = 1'b0;
  assign burst_arcache_o  = '0;
  assign burst_arprot_o   = '0;
  assign burst_arqos_o    = '0;
  assign burst_arregion_o = '0;
  assign burst_aruser_o   = '0;
  assign burst_arvalid_o  = arvalid_q;
  assign burst_rready_o   = in_data && pkt_tready_i;

  assign burst_awid_o     = '0;
  assign burst_awaddr_o   = '0;
  assign burst_awlen_o    = '0;
  assign burst_awsize_o   = '0;
  assign burst_awburst_o  = '0;
  assign burst_awlock_o   = 1'b0;
  assign burst_awcache_o  = '0;
  assign burst_awprot_o   = '0;
  assign burst_awqos_o    = '0;
  assign burst_awregion_o = '0;
  assign burst_awuser_o   = '0;
  assign burst_awvalid_o  = 1'b0;
  assign burst_wdata_o    = '0;
  assign burst_wstrb_o    = '0;
  assign burst_wlast_o    = 1'b0;
  assign burst_wuser_o    = '0;
  assign burst_wvalid_o   = 1'b0;
  assign burst_bready_o   = 1'b1;

  assign pkt_tdata_o  = burst_rdata_i;
  assign pkt_tstrb_o  = strb_c;
  assign pkt_tkeep_o  = strb_c;
  assign pkt_tlast_o  = in_data && last_word;
  assign pkt_tvalid_o = in_data && burst_rvalid_i;

  logic unused;
  assign unused = ^{burst_awready_i, burst_wready_i, burst_bid_i, burst_bresp_i,
                    burst_bvalid_i, burst_rid_i};

endmodule
